spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master_if.sv | 25 ++
 rtl/spi_master.sv | 116 +++++++++++
 tb/tb_spi_master.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// Host command/status bus plus SPI pins of the SPI master, bundled for one port.
// Latency: none, wiring only.
// Backpressure: the host must not issue start while busy; such starts are dropped.
interface spi_master_if;
    logic       start;
    logic [1:0] cmd_type;
    logic [7:0] din;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  start, cmd_type, din, MISO,
        output busy, done, rd_data, rd_valid, SS_n, MOSI
    );

    modport slave (
        output start, cmd_type, din, MISO,
        input  busy, done, rd_data, rd_valid, SS_n, MOSI
    );
endinterface

// File: rtl/spi_master.sv
// SPI master: sends a 10-bit {cmd_type,din} frame MSB first and, for rd-data frames, receives a byte on MISO.
// Latency: done on the 14th edge counting the start edge as the first (22+TURNAROUND for rd-data).
// Backpressure: none; start is only sampled in IDLE, so a start while busy is dropped.
module spi_master #(
    parameter int TURNAROUND = 2
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, SEL, CMD, SHIFT, HOLD, WAIT, RECV, STOP
    } state_t;

    localparam logic [3:0] TA_LOAD = 4'(TURNAROUND - 1);

    state_t     state;
    logic [9:0] frame;
    logic       is_rd;
    logic [3:0] cnt;

    // Outputs are updated on the same edge as the state they belong to,
    // so every pin is a flop and follows the state with no extra lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            frame        <= '0;
            is_rd        <= 1'b0;
            cnt          <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            bus.SS_n     <= 1'b1;
            bus.MOSI     <= 1'b0;
        end else begin
            bus.done     <= 1'b0;
            bus.rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= SEL;
                        frame    <= {bus.cmd_type, bus.din};
                        is_rd    <= (bus.cmd_type == 2'b11);
                        bus.busy <= 1'b1;
                        bus.SS_n <= 1'b0;
                        bus.MOSI <= 1'b0;
                    end
                end
                SEL: begin
                    state    <= CMD;
                    bus.MOSI <= frame[9];
                end
                CMD: begin
                    // frame shifts left so the next bit to send always sits in frame[9]
                    state    <= SHIFT;
                    bus.MOSI <= frame[9];
                    frame    <= {frame[8:0], 1'b0};
                    cnt      <= 4'd9;
                end
                SHIFT: begin
                    if (cnt == 4'd0) begin
                        state    <= HOLD;
                        bus.MOSI <= 1'b0;
                    end else begin
                        bus.MOSI <= frame[9];
                        frame    <= {frame[8:0], 1'b0};
                        cnt      <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (is_rd) begin
                        state <= WAIT;
                        cnt   <= TA_LOAD;
                    end else begin
                        state    <= STOP;
                        bus.SS_n <= 1'b1;
                        bus.done <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RECV;
                        cnt   <= 4'd7;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RECV: begin
                    // MISO is only ever looked at here
                    bus.rd_data <= {bus.rd_data[6:0], bus.MISO};
                    if (cnt == 4'd0) begin
                        state        <= STOP;
                        bus.SS_n     <= 1'b1;
                        bus.done     <= 1'b1;
                        bus.rd_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                STOP: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.SS_n <= 1'b1;
                    bus.MOSI <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: write/read frames, back-to-back, reset abort, ignored start.
// Edge counting: the start edge is edge 0; outputs are sampled on the following falling edge.
module tb_spi_master;

    localparam int TA = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_master_if bus();

    spi_master #(.TURNAROUND(TA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one frame starting from IDLE. Returns on the falling edge after the
    // STOP->IDLE edge, with the DUT back in IDLE.
    task automatic run_frame(input string tag, input logic [1:0] typ, input logic [7:0] d,
                             input logic [7:0] miso_byte, input bit hold_start,
                             input bit poke_start, input logic [10:0] exp_seq,
                             input logic [7:0] exp_rd);
        logic [10:0] seq;
        int          done_k;
        int          ss_low;
        int          last;
        int          recv0;
        int          idx;
        bit          is_rd;
        logic        rdv_at_done;
        logic        ss_at_done;
        is_rd        = (typ == 2'b11);
        last         = is_rd ? 21 + TA : 13;
        recv0        = 14 + TA;
        seq          = '0;
        ss_low       = 0;
        done_k       = -1;
        rdv_at_done  = 1'b0;
        ss_at_done   = 1'b0;
        bus.start    = 1'b1;
        bus.cmd_type = typ;
        bus.din      = d;
        for (int k = 0; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 0) begin
                check({tag, "_sel_ss"}, 32'(bus.SS_n), 32'd0);
                check({tag, "_sel_busy"}, 32'(bus.busy), 32'd1);
            end
            if (k >= 1 && k <= 11) seq = {seq[9:0], bus.MOSI};
            if (!bus.SS_n) ss_low++;
            if (bus.done) begin
                done_k      = k;
                rdv_at_done = bus.rd_valid;
                ss_at_done  = bus.SS_n;
            end
            if (!hold_start && k == 0) bus.start = 1'b0;
            if (poke_start && k == 4) begin
                bus.start    = 1'b1;
                bus.cmd_type = 2'b11;
                bus.din      = 8'hFF;
            end
            if (poke_start && k == 5) bus.start = 1'b0;
            // edge k+1 samples MISO: real data inside RECV, noise elsewhere
            if (is_rd && k + 1 >= recv0 && k + 1 < recv0 + 8) begin
                idx      = 7 - (k + 1 - recv0);
                bus.MISO = miso_byte[idx[2:0]];
            end else begin
                bus.MISO = 1'($urandom & 1);
            end
            if (done_k >= 0) break;
        end
        check({tag, "_mosi_seq"}, 32'(seq), 32'(exp_seq));
        check({tag, "_done_edge"}, 32'(done_k), 32'(last));
        check({tag, "_ss_low_cycles"}, 32'(ss_low), 32'(last));
        check({tag, "_ss_at_stop"}, 32'(ss_at_done), 32'd1);
        check({tag, "_rd_valid"}, 32'(rdv_at_done), 32'(is_rd));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_idle_ss"}, 32'(bus.SS_n), 32'd1);
        check({tag, "_rd_data"}, 32'(bus.rd_data), 32'(exp_rd));
    endtask

    initial begin
        int done_seen;
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.cmd_type = 2'b00;
        bus.din      = 8'hA5;
        bus.MISO     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ss", 32'(bus.SS_n), 32'd1);
        check("rst_mosi", 32'(bus.MOSI), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        rst = 1'b0;

        run_frame("wr_addr", 2'b00, 8'hA5, 8'h00, 1'b0, 1'b0, 11'b00010100101, 8'h00);
        run_frame("wr_data", 2'b01, 8'h3C, 8'h00, 1'b0, 1'b0, 11'b00100111100, 8'h00);
        run_frame("rd_data", 2'b11, 8'h5A, 8'h96, 1'b0, 1'b0, 11'b11101011010, 8'h96);

        run_frame("b2b_rd_addr", 2'b10, 8'h81, 8'h00, 1'b1, 1'b0, 11'b11010000001, 8'h96);
        run_frame("b2b_rd_data", 2'b11, 8'h00, 8'h3C, 1'b0, 1'b0, 11'b11100000000, 8'h3C);

        // abort a wr-data frame with reset on edge 5
        bus.start    = 1'b1;
        bus.cmd_type = 2'b01;
        bus.din      = 8'h77;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_ss", 32'(bus.SS_n), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        rst       = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done || bus.rd_valid || !bus.SS_n) done_seen++;
        end
        check("abort_no_activity", 32'(done_seen), 32'd0);
        check("abort_rd_data", 32'(bus.rd_data), 32'd0);

        run_frame("post_rst", 2'b00, 8'h0F, 8'h00, 1'b0, 1'b0, 11'b00000001111, 8'h00);
        run_frame("ign_start", 2'b01, 8'hC3, 8'h00, 1'b0, 1'b1, 11'b00111000011, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
